// File: rtl/regfile32.sv
// 32 x 32-bit register file: two combinational read ports (S, T) and one
// synchronous write port (D). Register 0 is hardwired to read as zero.
module regfile32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  S_Addr,
    input  logic [4:0]  T_Addr,
    input  logic [31:0] D,
    input  logic [4:0]  D_Addr,
    input  logic        D_En,
    output logic [31:0] S,
    output logic [31:0] T
);

    logic [31:0] memory [0:31];

    // Reset wins over a same-cycle write; writes to register 0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                memory[i] <= 32'h0;
            end
        end else if (D_En && (D_Addr != 5'd0)) begin
            memory[D_Addr] <= D;
        end
    end

    // No write bypass: a pending write shows up only after the capturing edge.
    assign S = (S_Addr == 5'd0) ? 32'h0 : memory[S_Addr];
    assign T = (T_Addr == 5'd0) ? 32'h0 : memory[T_Addr];

endmodule

// File: tb/tb_regfile32.sv
// Directed bench for regfile32: reset, load/dump, write-disable, register 0,
// same-cycle read/write ordering and synchronous reset behaviour.
module tb_regfile32;

    logic        clk;
    logic        reset;
    logic [4:0]  S_Addr;
    logic [4:0]  T_Addr;
    logic [31:0] D;
    logic [4:0]  D_Addr;
    logic        D_En;
    logic [31:0] S;
    logic [31:0] T;

    int errors;
    int checks;

    regfile32 uut (
        .clk    (clk),
        .reset  (reset),
        .S_Addr (S_Addr),
        .T_Addr (T_Addr),
        .D      (D),
        .D_Addr (D_Addr),
        .D_En   (D_En),
        .S      (S),
        .T      (T)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive a write on the falling edge; it is captured at the next rising edge.
    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data, input logic en);
        @(negedge clk);
        D_Addr = addr;
        D      = data;
        D_En   = en;
        @(posedge clk);
        #1;
        D_En   = 1'b0;
    endtask

    task automatic read_ports(input logic [4:0] sa, input logic [4:0] ta);
        @(negedge clk);
        S_Addr = sa;
        T_Addr = ta;
        #1;
    endtask

    function automatic logic [31:0] pattern(input int i);
        return 32'h1111_1111 * (i % 16) + i;
    endfunction

    function automatic logic [31:0] wb_value(input int i);
        logic [31:0] v;
        v = i;
        return v ^ 32'hA5A5_0000;
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        S_Addr = 5'd0;
        T_Addr = 5'd0;
        D      = 32'h0;
        D_Addr = 5'd0;
        D_En   = 1'b0;

        // Address 0 reads zero before any reset.
        #1;
        check("r0_before_reset_s", S, 32'h0);
        check("r0_before_reset_t", T, 32'h0);

        // Reset clears everything.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_ports(5'(i), 5'(31 - i));
            check("reset_clear_s", S, 32'h0);
            check("reset_clear_t", T, 32'h0);
        end

        // Load distinct patterns, then dump S 0..15 and T 16..31.
        for (int i = 1; i < 32; i++) write_reg(5'(i), pattern(i), 1'b1);
        for (int i = 0; i < 16; i++) begin
            read_ports(5'(i), 5'(i + 16));
            check("dump_s", S, (i == 0) ? 32'h0 : pattern(i));
            check("dump_t", T, pattern(i + 16));
        end
        check("mem_inspect_17", uut.memory[17], pattern(17));

        // Write-back values on every nonzero register, read on both ports.
        for (int i = 1; i < 32; i++) write_reg(5'(i), wb_value(i), 1'b1);
        for (int i = 0; i < 32; i++) begin
            read_ports(5'(i), 5'(i));
            check("wb_s", S, (i == 0) ? 32'h0 : wb_value(i));
            check("wb_t", T, (i == 0) ? 32'h0 : wb_value(i));
        end

        // Write disabled: register 5 keeps its value.
        write_reg(5'd5, 32'hDEAD_BEEF, 1'b0);
        read_ports(5'd5, 5'd5);
        check("wr_disable_s", S, 32'hA5A5_0005);
        check("wr_disable_t", T, 32'hA5A5_0005);

        // Write to register 0 is discarded.
        write_reg(5'd0, 32'hFFFF_FFFF, 1'b1);
        read_ports(5'd0, 5'd0);
        check("r0_write_s", S, 32'h0);
        check("r0_write_t", T, 32'h0);
        check("r0_write_mem", uut.memory[0], 32'h0);

        // Same-cycle read/write of register 7: old value before the edge.
        write_reg(5'd7, 32'h7, 1'b1);
        @(negedge clk);
        S_Addr = 5'd7;
        T_Addr = 5'd7;
        D_Addr = 5'd7;
        D      = 32'h77;
        D_En   = 1'b1;
        #1;
        check("rw_before_edge_s", S, 32'h7);
        check("rw_before_edge_t", T, 32'h7);
        @(posedge clk);
        #1;
        check("rw_after_edge_s", S, 32'h77);
        check("rw_after_edge_t", T, 32'h77);
        D_En = 1'b0;

        // Reset pulse between edges must change nothing.
        write_reg(5'd9, 32'h9999_0009, 1'b1);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        read_ports(5'd9, 5'd3);
        check("reset_glitch_9", S, 32'h9999_0009);
        check("reset_glitch_3", T, 32'hA5A5_0003);

        // Reset together with a write: reset wins, all registers read zero.
        @(negedge clk);
        reset  = 1'b1;
        D_En   = 1'b1;
        D_Addr = 5'd3;
        D      = 32'h1234;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        D_En  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_ports(5'(i), 5'(i));
            check("reset_with_write_s", S, 32'h0);
            check("reset_with_write_t", T, 32'h0);
        end

        // Register file still writable after reset.
        write_reg(5'd31, 32'hCAFE_F00D, 1'b1);
        read_ports(5'd31, 5'd30);
        check("post_reset_write", S, 32'hCAFE_F00D);
        check("post_reset_neighbor", T, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
